// File: rtl/stack_port_arbiter.sv
// Round-robin arbiter sharing one stack between two push/pop requesters.
// Each transaction runs IDLE -> ISSUE -> ACK; illegal ops are acked with err.
module stack_port_arbiter #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic             op0,
  input  logic             op1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             ack0,
  output logic             ack1,
  output logic             err,
  output logic [WIDTH-1:0] dout,
  output logic             busy,
  output logic             stk_push,
  output logic             stk_pop,
  output logic [WIDTH-1:0] stk_din,
  input  logic [WIDTH-1:0] stk_dout,
  input  logic             stk_empty,
  input  logic             stk_full
);

  typedef enum logic [1:0] {StIdle, StIssue, StAck} state_e;

  state_e           state_q, state_d;
  logic             last_gnt_q, last_gnt_d;
  logic             gnt_q, gnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] din_q, din_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             grant;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      op_q       <= 1'b0;
      din_q      <= '0;
      err_q      <= 1'b0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      op_q       <= op_d;
      din_q      <= din_d;
      err_q      <= err_d;
      dout_q     <= dout_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    op_d       = op_q;
    din_d      = din_q;
    err_d      = err_q;
    dout_d     = dout_q;
    grant      = 1'b0;
    stk_push   = 1'b0;
    stk_pop    = 1'b0;
    stk_din    = '0;
    ack0       = 1'b0;
    ack1       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          // On contention the port that did not win last time goes first.
          grant      = (req0 && req1) ? ~last_gnt_q : req1;
          gnt_d      = grant;
          last_gnt_d = grant;
          op_d       = grant ? op1 : op0;
          din_d      = grant ? din1 : din0;
          err_d      = 1'b0;
          state_d    = StIssue;
        end
      end
      StIssue: begin
        if (!op_q && !stk_full) begin
          stk_push = 1'b1;
          stk_din  = din_q;
        end else if (op_q && !stk_empty) begin
          stk_pop = 1'b1;
          dout_d  = stk_dout;
        end else begin
          err_d = 1'b1;
        end
        state_d = StAck;
      end
      StAck: begin
        ack0    = ~gnt_q;
        ack1    = gnt_q;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign err  = err_q;
  assign dout = dout_q;
  assign busy = (state_q != StIdle);

endmodule
